// File: rtl/sling_pkg.sv
// Shared types and constants for the slingshot sprite overlay: FSM state
// encoding, screen geometry and the power-on origin of the sprite.
package sling_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AIM    = 2'd1,
    RECOIL = 2'd2
  } sling_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int RST_X = 101;
  localparam int RST_Y = 325;

endpackage

// File: rtl/sprite_window.sv
// Combinational sprite hit test: reports whether (h_cnt, v_cnt) falls inside
// a W x H rectangle anchored at (x0, y0) and gives the local column/row.
module sprite_window #(
  parameter int CNT_W = 10,
  parameter int W     = 30,
  parameter int H     = 87
) (
  input  logic [CNT_W-1:0] h_cnt,
  input  logic [CNT_W-1:0] v_cnt,
  input  logic [CNT_W-1:0] x0,
  input  logic [CNT_W-1:0] y0,
  output logic             hit,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row
);

  // One extra bit so an origin near the right/bottom edge cannot wrap the
  // far edge around to a small value and produce a false hit at column 0.
  logic [CNT_W:0] x_last;
  logic [CNT_W:0] y_last;

  assign x_last = {1'b0, x0} + (CNT_W+1)'(W - 1);
  assign y_last = {1'b0, y0} + (CNT_W+1)'(H - 1);

  assign hit = (h_cnt >= x0) && ({1'b0, h_cnt} <= x_last) &&
               (v_cnt >= y0) && ({1'b0, v_cnt} <= y_last);

  assign col = h_cnt - x0;
  assign row = v_cnt - y0;

endmodule

// File: rtl/slingshot_sprite.sv
// Animated slingshot overlay: movable origin, multi-frame strip ROM addressing
// and an IDLE/AIM/RECOIL animation FSM. Optional horizontal flip: SLING_MIRROR_EN.
module slingshot_sprite
  import sling_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int W         = 30,
  parameter int H         = 87,
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 6,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic              frame_tick,
  input  logic [CNT_W-1:0]  pos_x,
  input  logic [CNT_W-1:0]  pos_y,
  input  logic              pull,
`ifdef SLING_MIRROR_EN
  input  logic              mirror,
`endif
  output logic              slingshot_valid,
  output logic [ADDR_W-1:0] slingshot_pixel_addr,
  output logic              fired,
  output logic              busy,
  output sling_state_t      state_dbg
);

  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W   = $clog2(FRAME_DIV + 1);

  // slingshot_valid is a per-pixel qualifier, not a handshake: there is no
  // ready, and it follows h_cnt/v_cnt with one clock of latency every cycle.

  sling_state_t       state;
  logic [FRAME_W-1:0] frame;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   x0;
  logic [CNT_W-1:0]   y0;

  logic               hit;
  logic [CNT_W-1:0]   col;
  logic [CNT_W-1:0]   row;
  logic [CNT_W-1:0]   col_sel;
  logic [ADDR_W-1:0]  addr_next;

  sprite_window #(
    .CNT_W (CNT_W),
    .W     (W),
    .H     (H)
  ) u_window (
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .x0    (x0),
    .y0    (y0),
    .hit   (hit),
    .col   (col),
    .row   (row)
  );

`ifdef SLING_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mirror_q <= 1'b0;
    end else if (frame_tick) begin
      mirror_q <= mirror;
    end
  end

  assign col_sel = mirror_q ? (CNT_W'(W - 1) - col) : col;
`else
  assign col_sel = col;
`endif

  assign addr_next = ADDR_W'(frame) * ADDR_W'(W * H) +
                     ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col_sel);

  // Origin, frame and state only move on frame_tick so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      div   <= '0;
      fired <= 1'b0;
      x0    <= CNT_W'(RST_X);
      y0    <= CNT_W'(RST_Y);
    end else begin
      fired <= 1'b0;
      if (frame_tick) begin
        x0 <= pos_x;
        y0 <= pos_y;
        case (state)
          IDLE: begin
            frame <= '0;
            if (pull) begin
              state <= AIM;
              frame <= FRAME_W'(1);
            end
          end
          AIM: begin
            if (!pull) begin
              state <= RECOIL;
              fired <= 1'b1;
              frame <= FRAME_W'(2);
              div   <= '0;
            end
          end
          RECOIL: begin
            if (div == DIV_W'(FRAME_DIV - 1)) begin
              div <= '0;
              if (frame == FRAME_W'(FRAMES - 1)) begin
                state <= IDLE;
                frame <= '0;
              end else begin
                frame <= frame + FRAME_W'(1);
              end
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            frame <= '0;
            div   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slingshot_valid      <= 1'b0;
      slingshot_pixel_addr <= '0;
    end else begin
      slingshot_valid      <= hit;
      slingshot_pixel_addr <= hit ? addr_next : '0;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_slingshot_sprite.sv
// Directed bench for slingshot_sprite: hit window, addressing, edge wrap,
// aim/recoil animation, async reset mid-recoil and the optional mirror.
module tb_slingshot_sprite;
  import sling_pkg::*;

  logic        clk;
  logic        rst;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_tick;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        pull;
  logic        mirror;
  logic        slingshot_valid;
  logic [13:0] slingshot_pixel_addr;
  logic        fired;
  logic        busy;
  sling_state_t state_dbg;

  int cmp_cnt;
  int err_cnt;

  slingshot_sprite dut (
    .clk                  (clk),
    .rst                  (rst),
    .h_cnt                (h_cnt),
    .v_cnt                (v_cnt),
    .frame_tick           (frame_tick),
    .pos_x                (pos_x),
    .pos_y                (pos_y),
    .pull                 (pull),
`ifdef SLING_MIRROR_EN
    .mirror               (mirror),
`endif
    .slingshot_valid      (slingshot_valid),
    .slingshot_pixel_addr (slingshot_pixel_addr),
    .fired                (fired),
    .busy                 (busy),
    .state_dbg            (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    step();
  endtask

  task automatic tick(input int px, input int py, input logic p);
    pos_x      = 10'(px);
    pos_y      = 10'(py);
    pull       = p;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    cmp_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b1;
    h_cnt      = '0;
    v_cnt      = '0;
    frame_tick = 1'b0;
    pos_x      = 10'd101;
    pos_y      = 10'd325;
    pull       = 1'b0;
    mirror     = 1'b0;
    step();
    step();
    check("rst_valid", 32'(slingshot_valid), 0);
    check("rst_addr", 32'(slingshot_pixel_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fired", 32'(fired), 0);
    rst = 1'b0;

    probe(101, 325);
    check("tl_valid", 32'(slingshot_valid), 1);
    check("tl_addr", 32'(slingshot_pixel_addr), 0);
    probe(130, 411);
    check("br_valid", 32'(slingshot_valid), 1);
    check("br_addr", 32'(slingshot_pixel_addr), 2609);
    probe(100, 325);
    check("left_valid", 32'(slingshot_valid), 0);
    check("left_addr", 32'(slingshot_pixel_addr), 0);
    probe(130, 412);
    check("below_valid", 32'(slingshot_valid), 0);
    check("below_addr", 32'(slingshot_pixel_addr), 0);
    probe(131, 325);
    check("right_valid", 32'(slingshot_valid), 0);

    // origin near the right edge: x span 1000..1029 must not wrap
    tick(1000, 325, 1'b0);
    check("idle_hold_busy", 32'(busy), 0);
    probe(1023, 325);
    check("edge_valid", 32'(slingshot_valid), 1);
    check("edge_addr", 32'(slingshot_pixel_addr), 23);
    probe(0, 325);
    check("nowrap_valid", 32'(slingshot_valid), 0);
    check("nowrap_addr", 32'(slingshot_pixel_addr), 0);

    // aim
    tick(101, 325, 1'b1);
    check("aim_busy", 32'(busy), 1);
    check("aim_state", 32'(state_dbg), 32'(AIM));
    probe(101, 325);
    check("aim_addr", 32'(slingshot_pixel_addr), 2610);
    check("aim_fired", 32'(fired), 0);

    // release -> recoil
    tick(101, 325, 1'b0);
    check("fire_pulse", 32'(fired), 1);
    probe(101, 325);
    check("fire_pulse_end", 32'(fired), 0);
    check("rec_f2_addr0", 32'(slingshot_pixel_addr), 5220);
    for (int i = 1; i < 6; i++) begin
      tick(101, 325, 1'b1);
      probe(101, 325);
      check("rec_f2_addr", 32'(slingshot_pixel_addr), 5220);
    end
    for (int i = 0; i < 6; i++) begin
      tick(101, 325, 1'b1);
      probe(101, 325);
      check("rec_f3_addr", 32'(slingshot_pixel_addr), 7830);
      check("rec_f3_busy", 32'(busy), 1);
    end
    tick(101, 325, 1'b0);
    probe(101, 325);
    check("end_addr", 32'(slingshot_pixel_addr), 0);
    check("end_busy", 32'(busy), 0);

    // async reset in the middle of a recoil and of a line
    tick(101, 325, 1'b1);
    tick(101, 325, 1'b0);
    probe(105, 330);
    check("pre_rst_addr", 32'(slingshot_pixel_addr), 5374);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(slingshot_valid), 0);
    check("midrst_addr", 32'(slingshot_pixel_addr), 0);
    step();
    rst = 1'b0;
    probe(105, 330);
    check("post_rst_valid", 32'(slingshot_valid), 1);
    check("post_rst_addr", 32'(slingshot_pixel_addr), 154);

    // horizontal flip request
    mirror = 1'b1;
    tick(101, 325, 1'b0);
    probe(101, 325);
`ifdef SLING_MIRROR_EN
    check("mirror_tl_addr", 32'(slingshot_pixel_addr), 29);
`else
    check("mirror_tl_addr", 32'(slingshot_pixel_addr), 0);
`endif
    probe(130, 325);
`ifdef SLING_MIRROR_EN
    check("mirror_tr_addr", 32'(slingshot_pixel_addr), 0);
`else
    check("mirror_tr_addr", 32'(slingshot_pixel_addr), 29);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
